// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types and constants: datapath widths, the NOP encoding,
// and the fetch-stage state encoding.
package mips_pkg;

  localparam int PC_WIDTH    = 32;
  localparam int INSTR_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0]    pc_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  localparam instr_t NOP_INSTR = '0;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_KILL = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  // Wraps modulo 2^PC_WIDTH, so 0xFFFFFFFC advances to 0.
  function automatic pc_t pc_plus4(input pc_t p);
    return p + pc_t'(4);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave).
interface fetch_stage_if;
  import mips_pkg::*;

  logic   req;
  pc_t    addr;
  logic   valid;
  instr_t rdata;

  modport master (output req, output addr, input valid, input rdata);
  modport slave  (input req, input addr, output valid, output rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, write-enable low holds every
// field, otherwise it loads an instruction or a fetch-stall bubble.
module if_id_reg
  import mips_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   write_en,
  input  logic   load,
  input  pc_t    pc4_d,
  input  instr_t instr_d,
  output pc_t    pc4,
  output instr_t instr,
  output logic   valid,
  output logic   fetch_stall
);

  // Flush beats the hazard-unit hold because a redirect kills the fetched slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc4         <= '0;
      instr       <= NOP_INSTR;
      valid       <= 1'b0;
      fetch_stall <= 1'b0;
    end else if (flush) begin
      pc4         <= '0;
      instr       <= NOP_INSTR;
      valid       <= 1'b0;
      fetch_stall <= 1'b0;
    end else if (write_en) begin
      if (load) begin
        pc4         <= pc4_d;
        instr       <= instr_d;
        valid       <= 1'b1;
        fetch_stall <= 1'b0;
      end else begin
        pc4         <= '0;
        instr       <= NOP_INSTR;
        valid       <= 1'b0;
        fetch_stall <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives instruction-memory requests,
// absorbs a response during a stall, and drains stale responses after a redirect.
module fetch_stage
  import mips_pkg::*;
#(
  parameter pc_t RESET_PC = '0
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   PCWrite,
  input  logic   if_id_Write,
  input  logic   branch_taken,
  input  pc_t    branch_target,
  input  logic   jump,
  input  pc_t    jump_target,
  fetch_stage_if.master imem,
  output pc_t    if_id_pc4,
  output instr_t if_id_instr,
  output logic   if_id_valid,
  output logic   fetch_stall
);

  fetch_state_e state, state_next;
  pc_t          pc, pc_next;
  pc_t          req_addr, req_addr_next;
  instr_t       hold_instr, hold_next;

  logic   redirect;
  pc_t    target;
  logic   avail;
  instr_t fetched;

  // Branch resolves in EX and is older than a jump decoded in ID, so it wins.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;

  assign avail   = ((state == FS_REQ) && imem.valid) || (state == FS_HOLD);
  assign fetched = (state == FS_HOLD) ? hold_instr : imem.rdata;

  assign imem.req  = (state == FS_REQ) || (state == FS_KILL);
  assign imem.addr = req_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FS_REQ;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      hold_instr <= NOP_INSTR;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      req_addr   <= req_addr_next;
      hold_instr <= hold_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    req_addr_next = req_addr;
    hold_next     = hold_instr;
    unique case (state)
      FS_REQ: begin
        if (redirect) begin
          // The address must stay stable until memory answers, so a redirect
          // without a response parks in KILL and reissues afterwards.
          pc_next = target;
          if (imem.valid) begin
            req_addr_next = target;
          end else begin
            state_next = FS_KILL;
          end
        end else if (imem.valid) begin
          if (if_id_Write) begin
            if (PCWrite) begin
              pc_next       = pc_plus4(pc);
              req_addr_next = pc_plus4(pc);
            end
          end else begin
            hold_next  = imem.rdata;
            state_next = FS_HOLD;
          end
        end
      end
      FS_KILL: begin
        if (redirect) begin
          pc_next = target;
        end
        if (imem.valid) begin
          req_addr_next = redirect ? target : pc;
          state_next    = FS_REQ;
        end
      end
      FS_HOLD: begin
        if (redirect) begin
          pc_next       = target;
          req_addr_next = target;
          state_next    = FS_REQ;
        end else if (if_id_Write) begin
          state_next = FS_REQ;
          if (PCWrite) begin
            pc_next       = pc_plus4(pc);
            req_addr_next = pc_plus4(pc);
          end
        end
      end
      default: state_next = FS_REQ;
    endcase
  end

  if_id_reg u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect),
    .write_en    (if_id_Write),
    .load        (avail),
    .pc4_d       (pc_plus4(req_addr)),
    .instr_d     (fetched),
    .pc4         (if_id_pc4),
    .instr       (if_id_instr),
    .valid       (if_id_valid),
    .fetch_stall (fetch_stall)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: a variable-latency memory, random stalls and
// redirects, and a scoreboard of the architectural fetch-address stream.
module tb_fetch_stage;
  import mips_pkg::*;

  localparam pc_t RESET_PC = 32'h0;

  logic   clk = 1'b0;
  logic   rst;
  logic   PCWrite, if_id_Write, branch_taken, jump;
  pc_t    branch_target, jump_target;
  pc_t    if_id_pc4;
  instr_t if_id_instr;
  logic   if_id_valid, fetch_stall;

  int checks = 0;
  int errors = 0;
  int deliveries = 0;
  pc_t exp_q[$];

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .if_id_Write   (if_id_Write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem          (imem),
    .if_id_pc4     (if_id_pc4),
    .if_id_instr   (if_id_instr),
    .if_id_valid   (if_id_valid),
    .fetch_stall   (fetch_stall)
  );

  always #5 clk = ~clk;

  function automatic instr_t instr_of(input pc_t a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5677;
  endfunction

  function automatic int new_lat();
    return ($urandom_range(0, 9) < 4) ? 0 : int'($urandom_range(1, 3));
  endfunction

  function automatic pc_t rand_target();
    pc_t t;
    t = pc_t'($urandom) & 32'h0000_0FFC;
    if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | (pc_t'($urandom) & 32'h0000_000C);
    return t;
  endfunction

  // Memory answers each request after a random number of cycles (possibly zero).
  int wait_cnt;
  int cur_lat;
  assign imem.valid = imem.req && (wait_cnt >= cur_lat);
  assign imem.rdata = imem.valid ? instr_of(imem.addr) : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 0;
      cur_lat  <= new_lat();
    end else if (imem.req && imem.valid) begin
      wait_cnt <= 0;
      cur_lat  <= new_lat();
    end else if (imem.req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkReset();
    checkOutput("rst_if_id_valid", 32'(if_id_valid), 32'd0);
    checkOutput("rst_if_id_instr", if_id_instr, 32'd0);
    checkOutput("rst_if_id_pc4", if_id_pc4, 32'd0);
    checkOutput("rst_fetch_stall", 32'(fetch_stall), 32'd0);
    checkOutput("rst_imem_req", 32'(imem.req), 32'd1);
    checkOutput("rst_imem_addr", imem.addr, RESET_PC);
  endtask

  // Redirects restart the expected stream at the winning target.
  task automatic applyStimulus(input bit dual_redirect);
    logic stall;
    @(negedge clk);
    stall         = ($urandom_range(0, 5) == 0);
    branch_taken  = ($urandom_range(0, 15) == 0);
    jump          = ($urandom_range(0, 15) == 0);
    branch_target = rand_target();
    jump_target   = rand_target();
    if (dual_redirect) begin
      stall         = 1'b1;
      branch_taken  = 1'b1;
      jump          = 1'b1;
      branch_target = 32'h200;
      jump_target   = 32'h300;
    end
    PCWrite     = !stall;
    if_id_Write = !stall;
    if (branch_taken) begin
      exp_q.delete();
      exp_q.push_back(branch_target);
    end else if (jump) begin
      exp_q.delete();
      exp_q.push_back(jump_target);
    end
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  // Monitor: classifies each edge as redirect bubble, hold, delivery or fetch bubble.
  initial begin
    logic w, r, was_rst, prev_wait;
    pc_t  prev_addr, s_pc4, exp_addr;
    instr_t s_instr;
    logic s_valid, s_stall;
    int   idle;
    prev_wait = 1'b0;
    prev_addr = '0;
    idle = 0;
    forever begin
      @(posedge clk);
      w = if_id_Write;
      r = branch_taken | jump;
      was_rst = rst;
      #1;
      if (!was_rst && !rst) begin
        if (prev_wait) begin
          checkOutput("imem_addr_stable", imem.addr, prev_addr);
          checkOutput("imem_req_held", 32'(imem.req), 32'd1);
        end
        idle++;
        if (r) begin
          checkOutput("redirect_valid", 32'(if_id_valid), 32'd0);
          checkOutput("redirect_instr", if_id_instr, 32'd0);
          checkOutput("redirect_pc4", if_id_pc4, 32'd0);
        end else if (!w) begin
          checkOutput("hold_pc4", if_id_pc4, s_pc4);
          checkOutput("hold_instr", if_id_instr, s_instr);
          checkOutput("hold_valid", 32'(if_id_valid), 32'(s_valid));
          checkOutput("hold_stall", 32'(fetch_stall), 32'(s_stall));
        end else if (if_id_valid) begin
          if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd1);
          end else begin
            exp_addr = exp_q.pop_front();
            checkOutput("deliver_pc4", if_id_pc4, exp_addr + 32'd4);
            checkOutput("deliver_instr", if_id_instr, instr_of(exp_addr));
            checkOutput("deliver_stall", 32'(fetch_stall), 32'd0);
          end
          deliveries++;
          idle = 0;
        end else begin
          checkOutput("bubble_stall", 32'(fetch_stall), 32'd1);
          checkOutput("bubble_instr", if_id_instr, 32'd0);
        end
        if (idle > 200) begin
          checkOutput("progress_watchdog", 32'(idle), 32'd0);
          idle = 0;
        end
      end
      s_pc4     = if_id_pc4;
      s_instr   = if_id_instr;
      s_valid   = if_id_valid;
      s_stall   = fetch_stall;
      prev_wait = imem.req && !imem.valid;
      prev_addr = imem.addr;
    end
  end

  initial begin
    rst           = 1'b0;
    PCWrite       = 1'b1;
    if_id_Write   = 1'b1;
    branch_taken  = 1'b0;
    jump          = 1'b0;
    branch_target = '0;
    jump_target   = '0;
    #1 rst = 1'b1;
    #11;
    checkReset();
    @(negedge clk);
    exp_q.push_back(RESET_PC);
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) applyStimulus(i == 300);

    // Asynchronous reset in the middle of a cycle; outputs must clear at once.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkReset();
    @(negedge clk);
    branch_taken = 1'b0;
    jump         = 1'b0;
    PCWrite      = 1'b1;
    if_id_Write  = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    rst = 1'b0;
    for (int i = 0; i < 1500; i++) applyStimulus(i == 700);

    @(negedge clk);
    checkOutput("deliveries_min", 32'(deliveries > 500), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
